// File: rtl/operand_bank.sv
// Double-buffered (ping-pong) multi-channel operand store.
// The producer fills one bank through a valid/ready handshake while the
// multiplier core drains the other bank in frames. Bank roles swap
// automatically as frames are committed and released.
module operand_bank #(
    parameter int N        = 8,    // operand MSB index, channel word is N+1 bits
    parameter int CHANNELS = 3,    // channels stored side by side per entry
    parameter int DEPTH    = 16,   // entries per bank, at least 2
    parameter int ADDR_W   = 4     // 2**ADDR_W must cover DEPTH
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_clear,
    input  logic [CHANNELS*(N+1)-1:0] i_wr_data,
    input  logic                      i_wr_valid,
    input  logic                      i_wr_last,
    output logic                      o_wr_ready,
    output logic [CHANNELS*(N+1)-1:0] o_rd_data,
    output logic                      o_rd_valid,
    output logic                      o_rd_last,
    input  logic                      i_rd_ready,
    output logic                      o_wr_bank,
    output logic                      o_rd_bank
);

    localparam int W      = CHANNELS * (N + 1);
    localparam int LEN_W  = ADDR_W + 1;          // holds a frame length of 1..DEPTH
    localparam int MEM_AW = ADDR_W + 1;          // bank select folded into the address

    localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
    localparam logic [MEM_AW-1:0] BANK1_BASE = MEM_AW'(DEPTH);

    typedef enum logic [1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_READY    = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    bank_state_t        r_state [2];
    logic [LEN_W-1:0]   r_len   [2];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               r_wr_ready;
    logic [W-1:0]       r_rd_data;
    logic               r_rd_valid;
    logic               r_rd_last;

    // Both banks share one array; bank 1 sits at offset DEPTH.
    logic [W-1:0]       r_mem [2*DEPTH];

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    bank_state_t        w_state_next [2];
    logic [LEN_W-1:0]   w_len_next   [2];
    logic [ADDR_W-1:0]  w_wr_ptr_next;
    logic [ADDR_W-1:0]  w_rd_ptr_next;
    logic               w_wr_bank_next;
    logic               w_rd_bank_next;
    logic               w_wr_ready_next;
    logic [W-1:0]       w_rd_data_next;
    logic               w_rd_valid_next;
    logic               w_rd_last_next;

    // ------------------------------------------------------------------
    // Per-bank status decode
    // ------------------------------------------------------------------
    logic [1:0] w_writable;       // bank may take writes (current state)
    logic [1:0] w_writable_next;  // bank may take writes (state after this edge)
    logic [1:0] w_is_ready;
    logic [1:0] w_is_draining;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_status
            assign w_writable[gi]      = (r_state[gi] == BANK_FREE) || (r_state[gi] == BANK_FILLING);
            assign w_writable_next[gi] = (w_state_next[gi] == BANK_FREE) ||
                                         (w_state_next[gi] == BANK_FILLING);
            assign w_is_ready[gi]      = (r_state[gi] == BANK_READY);
            assign w_is_draining[gi]   = (r_state[gi] == BANK_DRAINING);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write side decode
    // ------------------------------------------------------------------
    logic               w_wr_fire;
    logic               w_wr_commit;
    logic [MEM_AW-1:0]  w_wr_addr;

    // Clear wins over any transfer offered in the same cycle.
    assign w_wr_fire   = i_wr_valid && r_wr_ready && !i_clear;
    // The entry at DEPTH-1 closes the frame whether or not Wr_Last is set.
    assign w_wr_commit = w_wr_fire && (i_wr_last || (r_wr_ptr == LAST_PTR));
    assign w_wr_addr   = {1'b0, r_wr_ptr} + (r_wr_bank ? BANK1_BASE : '0);

    // ------------------------------------------------------------------
    // Read side decode
    // ------------------------------------------------------------------
    logic               w_rd_take;     // consumer accepts the output word
    logic               w_rd_release;  // accepted word closes the frame
    logic               w_src_bank;    // bank the next word would come from
    logic [ADDR_W-1:0]  w_src_ptr;
    logic               w_src_avail;
    logic               w_rd_load;
    logic [MEM_AW-1:0]  w_src_addr;
    logic [W-1:0]       w_src_word;
    logic               w_src_last;

    assign w_rd_take    = r_rd_valid && i_rd_ready;
    assign w_rd_release = w_rd_take && r_rd_last;

    // On a release the next word comes from the start of the other bank,
    // which keeps back-to-back frames free of bubbles.
    assign w_src_bank   = w_rd_release ? !r_rd_bank : r_rd_bank;
    assign w_src_ptr    = w_rd_release ? '0 : r_rd_ptr;

    // A draining bank still has words left exactly when the output
    // register does not already hold its final word.
    assign w_src_avail  = w_rd_release ? w_is_ready[!r_rd_bank]
                                       : (w_is_ready[r_rd_bank] ||
                                          (w_is_draining[r_rd_bank] && !(r_rd_valid && r_rd_last)));

    assign w_rd_load    = (!r_rd_valid || i_rd_ready) && w_src_avail && !i_clear;
    assign w_src_addr   = {1'b0, w_src_ptr} + (w_src_bank ? BANK1_BASE : '0);
    assign w_src_word   = r_mem[w_src_addr];
    assign w_src_last   = (({1'b0, w_src_ptr} + LEN_W'(1)) == r_len[w_src_bank]);

    // Wrap-around increment so pointers stay modulo DEPTH, not 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    // Next-state logic for bank lifecycles, pointers and the output register
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_next[b] = r_state[b];
            w_len_next[b]   = r_len[b];
        end
        w_wr_ptr_next   = r_wr_ptr;
        w_rd_ptr_next   = r_rd_ptr;
        w_wr_bank_next  = r_wr_bank;
        w_rd_bank_next  = r_rd_bank;
        w_wr_ready_next = 1'b0;
        w_rd_data_next  = r_rd_data;
        w_rd_valid_next = r_rd_valid;
        w_rd_last_next  = r_rd_last;

        if (i_clear) begin
            // Discard both banks; storage contents are left untouched.
            for (int b = 0; b < 2; b++) begin
                w_state_next[b] = BANK_FREE;
                w_len_next[b]   = '0;
            end
            w_wr_ptr_next   = '0;
            w_rd_ptr_next   = '0;
            w_wr_bank_next  = 1'b0;
            w_rd_bank_next  = 1'b0;
            w_rd_data_next  = '0;
            w_rd_valid_next = 1'b0;
            w_rd_last_next  = 1'b0;
        end else begin
            // Producer side: the write bank is always FREE or FILLING here.
            if (w_wr_fire) begin
                if (w_wr_commit) begin
                    w_state_next[r_wr_bank] = BANK_READY;
                    w_len_next[r_wr_bank]   = {1'b0, r_wr_ptr} + LEN_W'(1);
                    w_wr_ptr_next           = '0;
                    w_wr_bank_next          = !r_wr_bank;
                end else begin
                    w_state_next[r_wr_bank] = BANK_FILLING;
                    w_wr_ptr_next           = ptr_inc(r_wr_ptr);
                end
            end

            // Consumer side: release the drained bank, then refill the output.
            if (w_rd_release) begin
                w_state_next[r_rd_bank] = BANK_FREE;
                w_rd_bank_next          = !r_rd_bank;
                w_rd_ptr_next           = '0;
            end

            if (w_rd_load) begin
                w_state_next[w_src_bank] = BANK_DRAINING;
                w_rd_data_next           = w_src_word;
                w_rd_valid_next          = 1'b1;
                w_rd_last_next           = w_src_last;
                w_rd_ptr_next            = ptr_inc(w_src_ptr);
            end else if (w_rd_take) begin
                w_rd_valid_next = 1'b0;
                w_rd_last_next  = 1'b0;
            end

            // Ready only when the target bank is writable both now and after
            // this edge, so a just-released bank opens one edge later.
            w_wr_ready_next = w_writable_next[w_wr_bank_next] && w_writable[w_wr_bank_next];
        end
    end

    // Control and output registers, cleared asynchronously by reset
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= BANK_FREE;
                r_len[b]   <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= w_state_next[b];
                r_len[b]   <= w_len_next[b];
            end
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_bank  <= w_wr_bank_next;
            r_rd_bank  <= w_rd_bank_next;
            r_wr_ready <= w_wr_ready_next;
            r_rd_data  <= w_rd_data_next;
            r_rd_valid <= w_rd_valid_next;
            r_rd_last  <= w_rd_last_next;
        end
    end

    // Operand storage, written on accepted transfers and never reset
    always_ff @(posedge i_clock) begin
        if (w_wr_fire) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    assign o_wr_ready = r_wr_ready;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_last  = r_rd_last;
    assign o_wr_bank  = r_wr_bank;
    assign o_rd_bank  = r_rd_bank;

endmodule

// File: doc/operand_bank.md
Name: operand_bank

Overview:
- Multi-channel, double-buffered (ping-pong) operand store for the radix-8 Booth datapath.
- Generalises the fixed three-channel, fixed-bank operand memory:
  - channel count, depth and width are parametrised;
  - write and read address counters are internal;
  - bank swapping is automatic, not held static.
- The producer fills one bank through a valid/ready handshake while the multiplier core drains the other bank in frames.

Parameters:
- N, 8: operand MSB index; each channel word is N+1 bits.
- CHANNELS, 3: operand channels stored side by side per entry.
- DEPTH, 16: entries per bank; must be ≥2.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- Clock, input, 1: rising-edge clock.
- Reset_n, input, 1: asynchronous active-low reset.
- Clear, input, 1: synchronous discard of both banks.
- Wr_Data, input, CHANNELS*(N+1): packed channel words; channel k occupies bits [k*(N+1)+N : k*(N+1)].
- Wr_Valid, input, 1: write word offered.
- Wr_Last, input, 1: offered word ends the frame; qualified by Wr_Valid.
- Wr_Ready, output, 1: write bank can accept a word.
- Rd_Data, output, CHANNELS*(N+1): registered packed output word.
- Rd_Valid, output, 1: Rd_Data holds a valid word.
- Rd_Last, output, 1: Rd_Data is the final word of its frame.
- Rd_Ready, input, 1: consumer accepts Rd_Data.
- Wr_Bank, output, 1: bank currently being filled.
- Rd_Bank, output, 1: bank currently being drained.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - On reset: Wr_Ready=0 for the asserting cycle, then 1 from the first edge after release. Rd_Valid=0, Rd_Last=0, Rd_Data=0, Wr_Bank=0, Rd_Bank=0. All bank states FREE, all pointers 0.
  - Storage contents are not reset.
- Bank states (per bank): FREE -> FILLING (first accepted write) -> READY (commit) -> DRAINING (first word loaded into Rd_Data) -> FREE (last word accepted by consumer).
- Write side:
  - Transfer occurs when Wr_Valid && Wr_Ready.
  - Each transfer writes entry wr_ptr of Wr_Bank, then increments wr_ptr.
  - Commit happens on a transfer with Wr_Last=1, or on the transfer that writes entry DEPTH-1 (auto-commit; Wr_Last ignored there).
  - On commit: the frame length (1..DEPTH) is stored with the bank, the bank becomes READY, Wr_Bank toggles and wr_ptr resets to 0.
  - Wr_Ready = (bank Wr_Bank is FREE or FILLING) && !Clear. It is registered and reflects state after the previous edge.
  - If the other bank is still READY or DRAINING, Wr_Ready stays 0 until the edge after that bank returns to FREE.
- Read side:
  - Storage read is combinational from an internal register array. Rd_Data/Rd_Valid/Rd_Last form a single output register.
  - The output register loads when (!Rd_Valid || Rd_Ready) and a word is available from Rd_Bank (READY or DRAINING with rd_ptr < length).
  - Rd_Last = (rd_ptr == length-1) at load.
  - When the consumer accepts a word with Rd_Last=1: Rd_Bank becomes FREE and Rd_Bank toggles.
  - If a commit occurs at edge E, Rd_Valid is first 1 after edge E+1.
  - Sustained throughput is 1 word per cycle while Rd_Ready=1, including across frames: the first word of the next READY bank loads at the same edge the last word of the current frame is accepted.
  - While Rd_Valid=1 && Rd_Ready=0, Rd_Data and Rd_Last hold stable.
  - If no word is available when a word is accepted, Rd_Valid falls at that edge.
- Boundaries and simultaneous events:
  - Simultaneous write commit to one bank and release of the other bank at the same edge are legal and independent.
  - Both banks READY: Wr_Ready=0; no data is lost.
  - Wr_Valid with Wr_Ready=0: ignored, and the producer must hold its data.
  - Clear (sync) has the same effect as reset except storage; it overrides all same-cycle transfers.
  - Reset mid-frame: the partial frame is discarded; no READY bank survives.
  - Pointer arithmetic is modulo DEPTH, never 2^ADDR_W.

Test Plan:
1. Reset, then write 3 words 0x001/0x002/0x003 on channel 0 with Wr_Last on the third -> Wr_Bank 0->1; Rd_Valid rises 1 cycle after commit; reads 1,2,3 with Rd_Last only on 3; Rd_Bank ends at 1.
2. Write 16 words (DEPTH=16) with no Wr_Last, Rd_Ready=0 -> auto-commit after word 16. Then write 16 more -> second bank READY and Wr_Ready=0. Offer word 33 -> not accepted. Raise Rd_Ready -> 32 words read back-to-back with no gap; Rd_Last on words 16 and 32; Wr_Ready returns 1 the cycle after word 16 is accepted.
3. Rd_Ready toggling 1,0,0,1 during a 4-word frame -> Rd_Data stable while Rd_Ready=0; order preserved; no duplicate or missing words.
4. Single-word frame (Wr_Last on the first word, data 0x1FF on all 3 channels) -> Rd_Data = 27'h7FFFFFF with Rd_Valid=1 and Rd_Last=1 together.
5. Assert Reset_n=0 mid-frame after 5 writes and mid-read -> same cycle: Rd_Valid=0, Wr_Bank=0, Rd_Bank=0. After release, a new 2-word frame reads back only its own 2 words.
6. Clear asserted in the same cycle as a Wr_Last transfer -> no commit; Rd_Valid stays 0; both banks FREE.
